// File: rtl/sne_sram_arb_pkg.sv
// Shared types and default timing constants for the sne_sram arbiter/power sequencer.
package sne_sram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_ACTIVE = 2'd0,
      ARB_SLEEP  = 2'd1,
      ARB_WAKE   = 2'd2,
      ARB_GATED  = 2'd3
   } arb_state_e;

   localparam int unsigned DEFAULT_IDLE_CYCLES = 16;
   localparam int unsigned DEFAULT_WAKE_CYCLES = 4;

endpackage

// File: rtl/sne_rr_arbiter.sv
// One-hot round-robin picker: first requester at or after ptr_i wins, next_ptr_o points past it.
module sne_rr_arbiter #(
   parameter  int unsigned NUM_PORTS = 4,
   localparam int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
   input  logic [PTR_W-1:0]     ptr_i,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 en_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PTR_W-1:0]     gnt_idx_o,
   output logic [PTR_W-1:0]     next_ptr_o
);

   always_comb begin
      int unsigned idx;
      logic        found;
      idx        = 0;
      found      = 1'b0;
      gnt_o      = '0;
      gnt_idx_o  = '0;
      next_ptr_o = ptr_i;
      for (int unsigned off = 0; off < NUM_PORTS; off++) begin
         idx = 32'(ptr_i) + off;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = PTR_W'(idx);
            next_ptr_o = (idx == NUM_PORTS - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/sne_sram_arbiter.sv
// Round-robin arbiter and power sequencer for one sne_sram macro.
// Define SNE_SRAM_ARB_SLEEP_EN to enable the idle timer and automatic SLEEP entry.
module sne_sram_arbiter
   import sne_sram_arb_pkg::*;
#(
   parameter  int unsigned NUM_PORTS   = 4,
   parameter  int unsigned DATA_WIDTH  = 8,
   parameter  int unsigned NUM_WORDS   = 32,
   parameter  int unsigned IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
   parameter  int unsigned WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
   localparam int unsigned ADDR_WIDTH  = $clog2(NUM_WORDS)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 cfg_gate_i,
   input  logic [NUM_PORTS-1:0]                 req_i,
   input  logic [NUM_PORTS-1:0]                 we_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] be_i,
   output logic [NUM_PORTS-1:0]                 gnt_o,
   output logic [NUM_PORTS-1:0]                 rvalid_o,
   output logic [DATA_WIDTH-1:0]                rdata_o,
   output logic                                 sram_req_o,
   output logic                                 sram_we_o,
   output logic [ADDR_WIDTH-1:0]                sram_addr_o,
   output logic [DATA_WIDTH-1:0]                sram_wdata_o,
   output logic [DATA_WIDTH-1:0]                sram_be_o,
   input  logic [DATA_WIDTH-1:0]                sram_rdata_i,
   output logic                                 sram_power_sleep_o,
   output logic                                 sram_power_gate_o,
   output logic                                 busy_o
);

   localparam int unsigned PTR_W  = $clog2(NUM_PORTS);
   localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

   arb_state_e             state_q;
   logic [PTR_W-1:0]       ptr_q, ptr_next, gnt_idx;
   logic [NUM_PORTS-1:0]   gnt;
   logic                   gnt_en, any_req, any_gnt;
   logic [WAKE_W-1:0]      wake_cnt_q;
   logic                   gate_q;
   logic                   rsp_valid_q;
   logic [PTR_W-1:0]       rsp_port_q;
   logic                   held_we_q;
   logic [ADDR_WIDTH-1:0]  held_addr_q;
   logic [DATA_WIDTH-1:0]  held_wdata_q, held_be_q;

   assign any_req = |req_i;
   assign gnt_en  = (state_q == ARB_ACTIVE) && !rst_i;

   sne_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
      .ptr_i      (ptr_q),
      .req_i      (req_i),
      .en_i       (gnt_en),
      .gnt_o      (gnt),
      .gnt_idx_o  (gnt_idx),
      .next_ptr_o (ptr_next)
   );

   assign any_gnt = |gnt;
   assign gnt_o   = gnt;

   // Macro side follows the grantee combinationally and parks on the last access when idle
   assign sram_req_o   = any_gnt;
   assign sram_we_o    = any_gnt ? we_i[gnt_idx]    : held_we_q;
   assign sram_addr_o  = any_gnt ? addr_i[gnt_idx]  : held_addr_q;
   assign sram_wdata_o = any_gnt ? wdata_i[gnt_idx] : held_wdata_q;
   assign sram_be_o    = any_gnt ? be_i[gnt_idx]    : held_be_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_port_q   <= '0;
         held_we_q    <= 1'b0;
         held_addr_q  <= '0;
         held_wdata_q <= '0;
         held_be_q    <= '0;
      end else begin
         rsp_valid_q <= any_gnt && !we_i[gnt_idx];
         if (any_gnt) begin
            ptr_q        <= ptr_next;
            rsp_port_q   <= gnt_idx;
            held_we_q    <= we_i[gnt_idx];
            held_addr_q  <= addr_i[gnt_idx];
            held_wdata_q <= wdata_i[gnt_idx];
            held_be_q    <= be_i[gnt_idx];
         end
      end
   end

   // Responses are suppressed while reset is held so an in-flight read never leaks out
   always_comb begin
      rvalid_o = '0;
      if (rsp_valid_q && !rst_i) begin
         rvalid_o[rsp_port_q] = 1'b1;
      end
   end
   assign rdata_o = sram_rdata_i;

`ifdef SNE_SRAM_ARB_SLEEP_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES);
   logic [IDLE_W-1:0] idle_cnt_q;
   logic              sleep_q;
   assign sram_power_sleep_o = sleep_q;
`else
   assign sram_power_sleep_o = 1'b0;
`endif
   assign sram_power_gate_o = gate_q;

   // Power FSM: a gate request overrides every state; both SLEEP and GATED leave through WAKE
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ARB_ACTIVE;
         wake_cnt_q <= '0;
         gate_q     <= 1'b0;
`ifdef SNE_SRAM_ARB_SLEEP_EN
         sleep_q    <= 1'b0;
         idle_cnt_q <= '0;
`endif
      end else if (cfg_gate_i) begin
         state_q    <= ARB_GATED;
         wake_cnt_q <= '0;
         gate_q     <= 1'b1;
`ifdef SNE_SRAM_ARB_SLEEP_EN
         sleep_q    <= 1'b0;
         idle_cnt_q <= '0;
`endif
      end else begin
         case (state_q)
            ARB_ACTIVE: begin
`ifdef SNE_SRAM_ARB_SLEEP_EN
               if (any_req) begin
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
                  state_q    <= ARB_SLEEP;
                  sleep_q    <= 1'b1;
                  idle_cnt_q <= '0;
               end else begin
                  idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
               end
`endif
            end
`ifdef SNE_SRAM_ARB_SLEEP_EN
            ARB_SLEEP: begin
               if (any_req) begin
                  state_q    <= ARB_WAKE;
                  wake_cnt_q <= WAKE_W'(WAKE_CYCLES);
                  sleep_q    <= 1'b0;
               end
            end
`endif
            ARB_WAKE: begin
               if (wake_cnt_q <= WAKE_W'(1)) begin
                  state_q    <= ARB_ACTIVE;
                  wake_cnt_q <= '0;
               end else begin
                  wake_cnt_q <= wake_cnt_q - WAKE_W'(1);
               end
            end
            ARB_GATED: begin
               state_q    <= ARB_WAKE;
               wake_cnt_q <= WAKE_W'(WAKE_CYCLES);
               gate_q     <= 1'b0;
            end
            default: state_q <= ARB_ACTIVE;
         endcase
      end
   end

   assign busy_o = ((state_q != ARB_SLEEP) && (state_q != ARB_GATED)) || any_req;

endmodule

// File: tb/tb_sne_sram_arbiter.sv
// Self-checking bench for sne_sram_arbiter: table-driven arbitration vectors plus power sequences.
module tb_sne_sram_arbiter;

   localparam int NP = 4, DW = 8, NW = 32, AW = 5, IDLE = 16, WAKE = 4;

   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] be;
      logic [NP-1:0] egnt;
      logic [NP-1:0] ervalid;
      logic [DW-1:0] erdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst, cfgGate;
   logic [NP-1:0] req, we;
   logic [NP-1:0][AW-1:0] addr;
   logic [NP-1:0][DW-1:0] wdata, be;
   logic [NP-1:0] gnt, rvalid;
   logic [DW-1:0] rdata;
   logic sramReq, sramWe;
   logic [AW-1:0] sramAddr;
   logic [DW-1:0] sramWdata, sramBe, sramRdata;
   logic pSleep, pGate, busy;
   logic [DW-1:0] mem [NW];
   int checks = 0;
   int errors = 0;
   vec_t vecs [11];

   always #5 clk = ~clk;

   sne_sram_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW),
      .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .cfg_gate_i(cfgGate),
      .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .sram_req_o(sramReq), .sram_we_o(sramWe), .sram_addr_o(sramAddr),
      .sram_wdata_o(sramWdata), .sram_be_o(sramBe), .sram_rdata_i(sramRdata),
      .sram_power_sleep_o(pSleep), .sram_power_gate_o(pGate), .busy_o(busy)
   );

   function automatic logic [DW-1:0] memInit(input int i);
      if (i == 5) return 8'hA5;
      if (i == 3) return 8'h00;
      if (i >= 8 && i <= 11) return DW'(8'h10 + i - 8);
      return DW'(i) ^ 8'h5A;
   endfunction

   // Behavioural single-port macro with one-cycle read latency and bit-masked writes
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) mem[i] <= memInit(i);
         sramRdata <= '0;
      end else if (sramReq) begin
         if (sramWe) mem[sramAddr] <= (mem[sramAddr] & ~sramBe) | (sramWdata & sramBe);
         else sramRdata <= mem[sramAddr];
      end
   end

   function automatic int idxOf(input logic [NP-1:0] oh);
      for (int i = 0; i < NP; i++) if (oh[i]) return i;
      return 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      req = v.req;
      we  = v.we;
      for (int p = 0; p < NP; p++) begin
         addr[p]  = v.addr + AW'(p);
         wdata[p] = v.wdata;
         be[p]    = v.be;
      end
   endtask

   task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] w);
      req = r;
      we  = w;
      for (int p = 0; p < NP; p++) begin
         addr[p]  = AW'(16 + p);
         wdata[p] = 8'h00;
         be[p]    = 8'h00;
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      cfgGate = 1'b0;
      drive('0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Contention from reset, then single read, then masked write and read-back
      vecs[0]  = '{4'b1111, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b0001, 4'b0000, 8'h00};
      vecs[1]  = '{4'b1111, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b0010, 4'b0001, 8'h10};
      vecs[2]  = '{4'b1111, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b0100, 4'b0010, 8'h11};
      vecs[3]  = '{4'b1111, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b1000, 4'b0100, 8'h12};
      vecs[4]  = '{4'b1111, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b0001, 4'b1000, 8'h13};
      vecs[5]  = '{4'b0000, 4'b0000, 5'd8, 8'h00, 8'h00, 4'b0000, 4'b0001, 8'h10};
      vecs[6]  = '{4'b0100, 4'b0000, 5'd3, 8'h00, 8'h00, 4'b0100, 4'b0000, 8'h00};
      vecs[7]  = '{4'b0000, 4'b0000, 5'd3, 8'h00, 8'h00, 4'b0000, 4'b0100, 8'hA5};
      vecs[8]  = '{4'b0001, 4'b0001, 5'd3, 8'hFF, 8'h0F, 4'b0001, 4'b0000, 8'h00};
      vecs[9]  = '{4'b0001, 4'b0000, 5'd3, 8'h00, 8'h00, 4'b0001, 4'b0000, 8'h00};
      vecs[10] = '{4'b0000, 4'b0000, 5'd3, 8'h00, 8'h00, 4'b0000, 4'b0001, 8'h0F};

      rst = 1'b1;
      cfgGate = 1'b0;
      drive(4'b1111, '0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
      checkOutput("reset_sram_req", 32'(sramReq), 32'h0);
      checkOutput("reset_sleep", 32'(pSleep), 32'h0);
      checkOutput("reset_gate", 32'(pGate), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].egnt));
         checkOutput($sformatf("vec%0d_sram_req", i), 32'(sramReq), 32'(|vecs[i].egnt));
         checkOutput($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].ervalid));
         if (vecs[i].ervalid != '0)
            checkOutput($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].erdata));
         if (vecs[i].egnt != '0) begin
            checkOutput($sformatf("vec%0d_sram_addr", i), 32'(sramAddr),
                        32'(vecs[i].addr + AW'(idxOf(vecs[i].egnt))));
            checkOutput($sformatf("vec%0d_sram_we", i), 32'(sramWe),
                        32'(vecs[i].we[idxOf(vecs[i].egnt)]));
            if (vecs[i].we[idxOf(vecs[i].egnt)])
               checkOutput($sformatf("vec%0d_sram_be", i), 32'(sramBe), 32'(vecs[i].be));
         end
         nextCycle();
      end

`ifdef SNE_SRAM_ARB_SLEEP_EN
      // Sixteen idle cycles enter SLEEP; a request then wakes after WAKE+1 cycles
      resetDut();
      for (int c = 1; c <= IDLE; c++) begin
         @(negedge clk);
         if (c == IDLE) checkOutput("sleep_before_threshold", 32'(pSleep), 32'h0);
         nextCycle();
      end
      drive(4'b0010, '0);
      @(negedge clk);
      checkOutput("sleep_entered", 32'(pSleep), 32'h1);
      checkOutput("sleep_no_gnt", 32'(gnt), 32'h0);
      nextCycle();
      for (int k = 1; k <= WAKE + 1; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("wake_sleep_dropped", 32'(pSleep), 32'h0);
         checkOutput($sformatf("wake_gnt_t%0d", k), 32'(gnt), (k == WAKE + 1) ? 32'h2 : 32'h0);
         nextCycle();
      end
      drive('0, '0);
      @(negedge clk);
      checkOutput("wake_rvalid", 32'(rvalid), 32'h2);
      nextCycle();

      // A request in the threshold cycle is served and sleep is not entered
      resetDut();
      for (int c = 1; c < IDLE; c++) nextCycle();
      drive(4'b0001, '0);
      @(negedge clk);
      checkOutput("threshold_gnt", 32'(gnt), 32'h1);
      nextCycle();
      drive('0, '0);
      @(negedge clk);
      checkOutput("threshold_no_sleep", 32'(pSleep), 32'h0);
      checkOutput("threshold_rvalid", 32'(rvalid), 32'h1);
      nextCycle();
      drive(4'b1000, '0);
      @(negedge clk);
      checkOutput("threshold_still_active", 32'(gnt), 32'h8);
      nextCycle();
`else
      // Without the sleep feature a long idle stretch leaves the macro awake
      resetDut();
      for (int c = 1; c <= 3 * IDLE; c++) nextCycle();
      drive(4'b0001, '0);
      @(negedge clk);
      checkOutput("nosleep_pin", 32'(pSleep), 32'h0);
      checkOutput("nosleep_gnt", 32'(gnt), 32'h1);
      nextCycle();
`endif

      // Gate pulse with a pending read, then wake through WAKE
      resetDut();
      drive(4'b0010, '0);
      cfgGate = 1'b1;
      @(negedge clk);
      checkOutput("gate_entry_gnt", 32'(gnt), 32'h2);
      checkOutput("gate_entry_pin", 32'(pGate), 32'h0);
      nextCycle();
      cfgGate = 1'b0;
      @(negedge clk);
      checkOutput("gated_gnt", 32'(gnt), 32'h0);
      checkOutput("gated_pin", 32'(pGate), 32'h1);
      checkOutput("gated_sleep_pin", 32'(pSleep), 32'h0);
      checkOutput("gated_rvalid", 32'(rvalid), 32'h2);
      checkOutput("gated_busy", 32'(busy), 32'h1);
      nextCycle();
      for (int k = 1; k <= WAKE + 1; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("gate_wake_pin", 32'(pGate), 32'h0);
         checkOutput($sformatf("gate_wake_gnt_t%0d", k), 32'(gnt), (k == WAKE + 1) ? 32'h2 : 32'h0);
         nextCycle();
      end

      // Reset in the middle of WAKE returns straight to ACTIVE
      cfgGate = 1'b1;
      nextCycle();
      cfgGate = 1'b0;
      nextCycle();
      nextCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("wake_rst_gnt", 32'(gnt), 32'h0);
      checkOutput("wake_rst_sram_req", 32'(sramReq), 32'h0);
      checkOutput("wake_rst_rvalid", 32'(rvalid), 32'h0);
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_gnt", 32'(gnt), 32'h2);
      checkOutput("post_rst_gate", 32'(pGate), 32'h0);
      checkOutput("post_rst_sleep", 32'(pSleep), 32'h0);
      nextCycle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_drops_rvalid", 32'(rvalid), 32'h0);
      nextCycle();
      rst = 1'b0;
      drive('0, '0);
      @(negedge clk);
      checkOutput("rst_rvalid_cleared", 32'(rvalid), 32'h0);
      checkOutput("idle_active_busy", 32'(busy), 32'h1);
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
